// File: rtl/fir_coeff_sequencer_if.sv
// Host-side coefficient stream for fir_coeff_sequencer.
// master = host (drives start/valid/data), slave = sequencer (drives ready).
interface fir_coeff_sequencer_if #(
  parameter int CW = 16
);
  logic          cfg_start;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_data;

  modport master (output cfg_start, output cfg_valid, output cfg_data, input cfg_ready);
  modport slave  (input cfg_start, input cfg_valid, input cfg_data, output cfg_ready);
endinterface

// File: rtl/fir_coeff_sequencer.sv
// fir_coeff_sequencer: loads a coefficient set word-by-word into a shadow bank
// and swaps it onto the filter's packed coefficient bus on a sample-strobe
// boundary, so the filter never sees a mixed set within one sample.
// Also sequences the filter enable/bypass control.
// Optional feature macro: COEFF_CSUM_EN (adds a trailing checksum word and a
// one-cycle CHECK state; err pulses on mismatch).
module fir_coeff_sequencer #(
  parameter int NTAPS = 7,
  parameter int CW    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_stb,
  fir_coeff_sequencer_if.slave  cfg,
  input  logic                  byp_req,
  output logic [NTAPS*CW-1:0]   coeff_out,
  output logic                  filt_en,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

`ifdef COEFF_CSUM_EN
  localparam int NWORDS = NTAPS + 1;
  typedef enum logic [1:0] {IDLE, LOAD, ARMED, CHECK} state_t;
`else
  localparam int NWORDS = NTAPS;
  typedef enum logic [1:0] {IDLE, LOAD, ARMED} state_t;
`endif
  localparam int IW = $clog2(NWORDS + 1);

  state_t                   state;
  logic [IW-1:0]            idx;
  logic                     loaded;
  logic                     ready_q;
  logic [NTAPS-1:0][CW-1:0] shadow;
  logic [NTAPS-1:0][CW-1:0] active;

  logic accept, commit, last_word;

  assign accept    = cfg.cfg_valid & ready_q;
  assign commit    = (state == ARMED) & sample_stb;
  assign last_word = (idx == IW'(NWORDS - 1));

  assign cfg.cfg_ready = ready_q;
  assign busy          = (state != IDLE);

  // Active set to the filter bus: entry 0 (coeff1) lands in the MSBs.
  for (genvar k = 0; k < NTAPS; k++) begin : g_pack
    assign coeff_out[(NTAPS-k)*CW-1 -: CW] = active[k];
  end

`ifdef COEFF_CSUM_EN
  logic [CW-1:0] csum_word;
  logic [CW-1:0] csum_calc;
  logic          err_q;

  assign err = err_q;

  // Modulo-2^CW sum of the shadow bank, compared against the received check word.
  always_comb begin
    csum_calc = '0;
    for (int k = 0; k < NTAPS; k++) csum_calc = csum_calc + shadow[k];
  end
`else
  assign err = 1'b0;
`endif

  // Sequencer FSM with registered ready/done/filt_en and the active bank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      loaded  <= 1'b0;
      ready_q <= 1'b0;
      shadow  <= '0;
      active  <= '0;
      filt_en <= 1'b0;
      done    <= 1'b0;
`ifdef COEFF_CSUM_EN
      csum_word <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef COEFF_CSUM_EN
      err_q <= 1'b0;
`endif
      // Enable follows bypass request only at strobes; a commit in this same
      // cycle already counts as loaded.
      if (sample_stb) filt_en <= (loaded | commit) & ~byp_req;

      case (state)
        IDLE: begin
          if (cfg.cfg_start) begin
            state   <= LOAD;
            idx     <= '0;
            ready_q <= 1'b1;
          end
        end

        LOAD: begin
          if (cfg.cfg_start) begin
            // Restart: partially written shadow words just get overwritten.
            idx <= '0;
          end else if (accept) begin
            for (int k = 0; k < NTAPS; k++)
              if (idx == IW'(k)) shadow[k] <= cfg.cfg_data;
`ifdef COEFF_CSUM_EN
            if (last_word) csum_word <= cfg.cfg_data;
`endif
            if (last_word) begin
              ready_q <= 1'b0;
`ifdef COEFF_CSUM_EN
              state   <= CHECK;
`else
              state   <= ARMED;
`endif
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end

`ifdef COEFF_CSUM_EN
        CHECK: begin
          if (cfg.cfg_start) begin
            state   <= LOAD;
            idx     <= '0;
            ready_q <= 1'b1;
          end else if (csum_calc == csum_word) begin
            state <= ARMED;
          end else begin
            err_q <= 1'b1;
            state <= IDLE;
          end
        end
`endif

        ARMED: begin
          if (sample_stb) begin
            active <= shadow;
            done   <= 1'b1;
            loaded <= 1'b1;
          end
          // A start arriving with the strobe still lets the commit through.
          if (cfg.cfg_start) begin
            state   <= LOAD;
            idx     <= '0;
            ready_q <= 1'b1;
          end else if (sample_stb) begin
            state <= IDLE;
          end
        end

        default: begin
          state   <= IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_coeff_sequencer.sv
// Self-checking bench for fir_coeff_sequencer: queue-based reference model
// compared every cycle, plus directed literal expectations.
module tb_fir_coeff_sequencer;
  localparam int NTAPS = 7;
  localparam int CW    = 16;
`ifdef COEFF_CSUM_EN
  localparam int NW = NTAPS + 1;
`else
  localparam int NW = NTAPS;
`endif

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                sample_stb = 1'b0;
  logic                byp_req = 1'b0;
  logic [NTAPS*CW-1:0] coeff_out;
  logic                filt_en, busy, done, err;

  fir_coeff_sequencer_if #(.CW(CW)) cfg ();

  fir_coeff_sequencer #(.NTAPS(NTAPS), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .sample_stb (sample_stb),
    .cfg        (cfg.slave),
    .byp_req    (byp_req),
    .coeff_out  (coeff_out),
    .filt_en    (filt_en),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  bit stb_on = 1'b0;
  int acc_cnt = 0, done_cnt = 0, err_cnt = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [NTAPS*CW-1:0] m_coeff = '0;
  bit m_filt, m_loaded, m_done, m_err, m_ready, m_busy;
  bit in_load, armed, checking;
  logic [15:0] mq[$];

  initial forever begin : model
    bit commit;
    logic [15:0] s;
    @(posedge clk);
    if (reset) begin
      m_coeff = '0; m_filt = 0; m_loaded = 0; m_done = 0; m_err = 0;
      m_ready = 0; m_busy = 0; in_load = 0; armed = 0; checking = 0;
      mq.delete();
    end else begin
      acc_cnt += int'(cfg.cfg_valid && cfg.cfg_ready);
      commit = armed && sample_stb;
      m_done = 0;
      m_err  = 0;
      if (sample_stb) m_filt = (m_loaded || commit) && !byp_req;
      if (armed) begin
        if (commit) begin
          for (int k = 0; k < NTAPS; k++) m_coeff[(NTAPS-k)*CW-1 -: CW] = mq[k];
          m_done = 1; m_loaded = 1; armed = 0;
        end
        if (cfg.cfg_start) begin armed = 0; in_load = 1; mq.delete(); end
      end else if (checking) begin
        checking = 0;
        if (cfg.cfg_start) begin
          in_load = 1; mq.delete();
        end else begin
          s = '0;
          for (int k = 0; k < NTAPS; k++) s = s + mq[k];
          if (s == mq[NTAPS]) armed = 1; else m_err = 1;
        end
      end else if (in_load) begin
        if (cfg.cfg_start) mq.delete();
        else if (cfg.cfg_valid) begin
          mq.push_back(cfg.cfg_data);
          if (mq.size() == NW) begin
            in_load = 0;
`ifdef COEFF_CSUM_EN
            checking = 1;
`else
            armed = 1;
`endif
          end
        end
      end else if (cfg.cfg_start) begin
        in_load = 1; mq.delete();
      end
      m_ready = in_load;
      m_busy  = in_load || armed || checking;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      check("coeff_out", 128'(coeff_out), 128'(m_coeff));
      check("filt_en",   128'(filt_en),   128'(m_filt));
      check("cfg_ready", 128'(cfg.cfg_ready), 128'(m_ready));
      check("busy",      128'(busy),      128'(m_busy));
      check("done",      128'(done),      128'(m_done));
      check("err",       128'(err),       128'(m_err));
      done_cnt += int'(done);
      err_cnt  += int'(err);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    cyc++;
    sample_stb = stb_on && (cyc % 8 == 0);
  endtask

  task automatic start_pulse();
    cfg.cfg_start = 1'b1;
    tick();
    cfg.cfg_start = 1'b0;
  endtask

  task automatic put_word(input logic [15:0] w, input int gap);
    bit ok;
    int n;
    cfg.cfg_valid = 1'b0;
    repeat (gap) tick();
    cfg.cfg_valid = 1'b1;
    cfg.cfg_data  = w;
    n = 0;
    do begin
      ok = cfg.cfg_ready;
      tick();
      n++;
    end while (!ok && n < 50);
    if (!ok) check("word_accept_timeout", 0, 1);
    cfg.cfg_valid = 1'b0;
  endtask

  task automatic send_set(input logic [15:0] w [NTAPS], input int gap, input bit bad_csum);
    logic [15:0] s;
    s = '0;
    start_pulse();
    for (int k = 0; k < NTAPS; k++) begin
      put_word(w[k], gap);
      s = s + w[k];
    end
`ifdef COEFF_CSUM_EN
    put_word(s + 16'(bad_csum), gap);
`else
    if (bad_csum) s = '0;
`endif
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin tick(); n++; end
    if (!done) check("done_timeout", 0, 1);
  endtask

  // Returns just after the next strobe edge has been clocked.
  task automatic wait_stb_edge();
    int n = 0;
    while (!sample_stb && n < 20) begin tick(); n++; end
    if (!sample_stb) check("strobe_timeout", 0, 1);
    tick();
  endtask

  logic [15:0] w [NTAPS];

  // ---------------- directed tests ----------------
  initial begin
    cfg.cfg_start = 1'b0;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_data  = '0;
    repeat (3) tick();
    check("rst_coeff", 128'(coeff_out), 0);
    check("rst_filt",  128'(filt_en), 0);
    check("rst_ready", 128'(cfg.cfg_ready), 0);
    check("rst_busy",  128'(busy), 0);
    check("rst_done",  128'(done), 0);
    reset = 1'b0;
    stb_on = 1'b1;
    tick();

    // 1: basic load
    for (int k = 0; k < NTAPS; k++) w[k] = 16'((k + 1) * 16'h0100);
    send_set(w, 0, 0);
    wait_done();
    check("t1_coeff", 128'(coeff_out), 128'(112'h0100_0200_0300_0400_0500_0600_0700));
    check("t1_filt_en", 128'(filt_en), 1);

    // 2: abort mid-set
    tick();
    done_cnt = 0;
    start_pulse();
    repeat (3) put_word(16'h7FFF, 0);
    for (int k = 0; k < NTAPS; k++) w[k] = 16'h1111;
    send_set(w, 0, 0);
    wait_done();
    repeat (20) tick();
    check("t2_coeff", 128'(coeff_out), 128'(112'h1111_1111_1111_1111_1111_1111_1111));
    check("t2_done_cnt", 128'(done_cnt), 1);

    // 3: valid held outside LOAD, gaps inside LOAD
    cfg.cfg_valid = 1'b1;
    cfg.cfg_data  = 16'hAAAA;
    repeat (5) tick();
    acc_cnt = 0;
    for (int k = 0; k < NTAPS; k++) w[k] = 16'((k + 1) * 16'h0101);
    send_set(w, 5, 0);
    cfg.cfg_valid = 1'b1;
    cfg.cfg_data  = 16'hBEEF;
    wait_done();
    repeat (4) tick();
    cfg.cfg_valid = 1'b0;
    tick();
    check("t3_accepted", 128'(acc_cnt), 128'(NW));
    check("t3_coeff", 128'(coeff_out), 128'(112'h0101_0202_0303_0404_0505_0606_0707));

    // 4: bypass
    wait_stb_edge();
    byp_req = 1'b1;
    repeat (3) tick();
    check("t4_filt_hold", 128'(filt_en), 1);
    wait_stb_edge();
    check("t4_filt_byp", 128'(filt_en), 0);
    byp_req = 1'b0;
    wait_stb_edge();
    check("t4_filt_resume", 128'(filt_en), 1);

    // 5: start colliding with strobe in ARMED, then reset mid-load
    stb_on = 1'b0;
    for (int k = 0; k < NTAPS; k++) w[k] = 16'(16'h0A01 + k);
    send_set(w, 0, 0);
    repeat (2) tick();
    sample_stb = 1'b1;
    cfg.cfg_start = 1'b1;
    tick();
    cfg.cfg_start = 1'b0;
    check("t5_done", 128'(done), 1);
    check("t5_busy", 128'(busy), 1);
    check("t5_ready", 128'(cfg.cfg_ready), 1);
    check("t5_coeff", 128'(coeff_out), 128'(112'h0A01_0A02_0A03_0A04_0A05_0A06_0A07));
    stb_on = 1'b1;
    repeat (4) put_word(16'h5555, 0);
    reset = 1'b1;
    #1;
    check("t5_rst_coeff", 128'(coeff_out), 0);
    check("t5_rst_filt", 128'(filt_en), 0);
    check("t5_rst_ready", 128'(cfg.cfg_ready), 0);
    repeat (2) tick();
    reset = 1'b0;
    wait_stb_edge();
    check("t5_filt_unloaded", 128'(filt_en), 0);

`ifdef COEFF_CSUM_EN
    // 6: checksum good then bad
    for (int k = 0; k < NTAPS; k++) w[k] = 16'h1000;
    send_set(w, 0, 0);
    wait_done();
    check("t6_coeff", 128'(coeff_out), 128'(112'h1000_1000_1000_1000_1000_1000_1000));
    tick();
    err_cnt = 0;
    done_cnt = 0;
    send_set(w, 0, 1);
    repeat (20) tick();
    check("t6_err_cnt", 128'(err_cnt), 1);
    check("t6_done_cnt", 128'(done_cnt), 0);
    check("t6_coeff_kept", 128'(coeff_out), 128'(112'h1000_1000_1000_1000_1000_1000_1000));
`endif

    repeat (4) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
